// File: rtl/i3c_bus_input_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// i3c_bus_input_conditioner_pkg
//   Shared types and default sizes for the I3C pad-input conditioner.
//   bus_events_t bundles the one-cycle bus event pulses so the I3C core can
//   consume a single struct instead of five loose wires.
// ---------------------------------------------------------------------------
package i3c_bus_input_conditioner_pkg;

  localparam int unsigned DefSyncStages   = 2;
  localparam int unsigned DefFiltCntWidth = 5;
  localparam int unsigned DefIdleCntWidth = 20;

  typedef struct packed {
    logic scl_pos;
    logic scl_neg;
    logic start;
    logic rstart;
    logic stop;
  } bus_events_t;

endpackage

// File: rtl/i3c_bus_input_conditioner_if.sv
// ---------------------------------------------------------------------------
// i3c_bus_input_conditioner_if
//   Bundles the raw pad inputs, filter/idle configuration and the conditioned
//   bus outputs of the input conditioner.
//   master : conditioner side (consumes pins + config, drives outputs)
//   slave  : pad ring / core side (drives pins + config, consumes outputs)
// ---------------------------------------------------------------------------
interface i3c_bus_input_conditioner_if #(
  parameter int unsigned FiltCntWidth = i3c_bus_input_conditioner_pkg::DefFiltCntWidth,
  parameter int unsigned IdleCntWidth = i3c_bus_input_conditioner_pkg::DefIdleCntWidth
) ();
  import i3c_bus_input_conditioner_pkg::*;

  // raw pins and configuration
  logic                    scl_i;
  logic                    sda_i;
  logic                    filt_en_i;
  logic [FiltCntWidth-1:0] filt_cycles_i;
  logic [IdleCntWidth-1:0] t_idle_i;

  // conditioned bus view
  logic                    scl_o;
  logic                    sda_o;
  logic                    scl_posedge_o;
  logic                    scl_negedge_o;
  logic                    start_det_o;
  logic                    rstart_det_o;
  logic                    stop_det_o;
  logic                    bus_busy_o;
  logic                    bus_idle_o;
  bus_events_t             events_o;

  modport master (
    input  scl_i, sda_i, filt_en_i, filt_cycles_i, t_idle_i,
    output scl_o, sda_o, scl_posedge_o, scl_negedge_o, start_det_o,
           rstart_det_o, stop_det_o, bus_busy_o, bus_idle_o, events_o
  );

  modport slave (
    output scl_i, sda_i, filt_en_i, filt_cycles_i, t_idle_i,
    input  scl_o, sda_o, scl_posedge_o, scl_negedge_o, start_det_o,
           rstart_det_o, stop_det_o, bus_busy_o, bus_idle_o, events_o
  );

endinterface

// File: rtl/i3c_bus_input_conditioner_line_filter.sv
// ---------------------------------------------------------------------------
// i3c_bus_input_conditioner_line_filter
//   One bus line: SyncStages-deep synchronizer, programmable spike filter,
//   one-cycle delayed copy and edge pulses.
//   clk_i, rst_ni    : clock, async active-low reset
//   line_i           : raw asynchronous pad level
//   filt_en_i        : 1 = spike filter active
//   filt_cycles_i    : stable cycles required before the filtered level moves
//   line_o           : filtered level
//   pos_o / neg_o    : one-cycle pulses on filtered rise / fall
// ---------------------------------------------------------------------------
module i3c_bus_input_conditioner_line_filter
  import i3c_bus_input_conditioner_pkg::*;
#(
  parameter int unsigned SyncStages   = DefSyncStages,
  parameter int unsigned FiltCntWidth = DefFiltCntWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    line_i,
  input  logic                    filt_en_i,
  input  logic [FiltCntWidth-1:0] filt_cycles_i,
  output logic                    line_o,
  output logic                    pos_o,
  output logic                    neg_o
);

  localparam logic [FiltCntWidth:0] CntOne = 1;

  logic [SyncStages-1:0]   sync_q;
  logic                    filt_q, filt_d;
  logic                    dly_q;
  logic [FiltCntWidth-1:0] cnt_q, cnt_d;
  logic                    line_s;
  logic                    bypass;
  logic [FiltCntWidth:0]   cnt_inc;

  assign line_s  = sync_q[SyncStages-1];
  assign bypass  = !filt_en_i || (filt_cycles_i == '0);
  // One bit wider so the compare against filt_cycles_i cannot wrap.
  assign cnt_inc = {1'b0, cnt_q} + CntOne;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (bypass) begin
      filt_d = line_s;
      cnt_d  = '0;
    end else if (line_s != filt_q) begin
      if (cnt_inc >= {1'b0, filt_cycles_i}) begin
        filt_d = line_s;
        cnt_d  = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_inc[FiltCntWidth-1:0];
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Everything resets high: an idle I3C bus is pulled up.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
      filt_q <= 1'b1;
      dly_q  <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], line_i};
      filt_q <= filt_d;
      dly_q  <= filt_q;
      cnt_q  <= cnt_d;
    end
  end

  assign line_o = filt_q;
  assign pos_o  = filt_q & ~dly_q;
  assign neg_o  = ~filt_q & dly_q;

endmodule

// File: rtl/i3c_bus_input_conditioner.sv
// ---------------------------------------------------------------------------
// i3c_bus_input_conditioner
//   Conditions raw SCL/SDA pad inputs for the I3C core: per-line sync + spike
//   filter, then START / Repeated-START / STOP detection, bus-busy flag and
//   bus-idle timer.
//   clk_i  : core clock
//   rst_ni : async reset, active low
//   bus    : master modport of i3c_bus_input_conditioner_if (pins, config,
//            conditioned lines, event pulses, busy/idle)
// ---------------------------------------------------------------------------
module i3c_bus_input_conditioner
  import i3c_bus_input_conditioner_pkg::*;
#(
  parameter int unsigned SyncStages   = DefSyncStages,
  parameter int unsigned FiltCntWidth = DefFiltCntWidth,
  parameter int unsigned IdleCntWidth = DefIdleCntWidth
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  i3c_bus_input_conditioner_if.master    bus
);

  localparam logic [IdleCntWidth:0] IdleOne = 1;

  logic scl_f, scl_pos, scl_neg;
  logic sda_f, sda_pos, sda_neg;
  logic start_w, stop_w;
  logic busy_q, busy_d;
  logic idle_q, idle_d;
  logic [IdleCntWidth-1:0] icnt_q, icnt_d;
  logic [IdleCntWidth:0]   icnt_inc;

  i3c_bus_input_conditioner_line_filter #(
    .SyncStages  (SyncStages),
    .FiltCntWidth(FiltCntWidth)
  ) u_scl_filt (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .line_i       (bus.scl_i),
    .filt_en_i    (bus.filt_en_i),
    .filt_cycles_i(bus.filt_cycles_i),
    .line_o       (scl_f),
    .pos_o        (scl_pos),
    .neg_o        (scl_neg)
  );

  i3c_bus_input_conditioner_line_filter #(
    .SyncStages  (SyncStages),
    .FiltCntWidth(FiltCntWidth)
  ) u_sda_filt (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .line_i       (bus.sda_i),
    .filt_en_i    (bus.filt_en_i),
    .filt_cycles_i(bus.filt_cycles_i),
    .line_o       (sda_f),
    .pos_o        (sda_pos),
    .neg_o        (sda_neg)
  );

  // SCL must be high now and in the previous cycle; scl_f & ~scl_pos is
  // exactly that, so an SCL edge in the same cycle suppresses START/STOP.
  assign start_w = sda_neg & scl_f & ~scl_pos;
  assign stop_w  = sda_pos & scl_f & ~scl_pos;

  assign icnt_inc = {1'b0, icnt_q} + IdleOne;

  always_comb begin
    busy_d = busy_q;
    if (start_w) begin
      busy_d = 1'b1;
    end else if (stop_w) begin
      busy_d = 1'b0;
    end
  end

  // Idle timer only runs on a free bus; any low level or START restarts it.
  always_comb begin
    icnt_d = icnt_q;
    idle_d = idle_q;
    if (start_w || !scl_f || !sda_f) begin
      icnt_d = '0;
      idle_d = 1'b0;
    end else if (!busy_q) begin
      if (icnt_inc >= {1'b0, bus.t_idle_i}) begin
        idle_d = 1'b1;
      end
      if (icnt_q != '1) begin
        icnt_d = icnt_inc[IdleCntWidth-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      idle_q <= 1'b0;
      icnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      idle_q <= idle_d;
      icnt_q <= icnt_d;
    end
  end

  assign bus.scl_o         = scl_f;
  assign bus.sda_o         = sda_f;
  assign bus.scl_posedge_o = scl_pos;
  assign bus.scl_negedge_o = scl_neg;
  assign bus.start_det_o   = start_w & ~busy_q;
  assign bus.rstart_det_o  = start_w & busy_q;
  assign bus.stop_det_o    = stop_w;
  assign bus.bus_busy_o    = busy_q;
  assign bus.bus_idle_o    = idle_q;
  assign bus.events_o      = '{scl_pos: scl_pos, scl_neg: scl_neg,
                               start: start_w & ~busy_q,
                               rstart: start_w & busy_q, stop: stop_w};

endmodule
